// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
// Responder side of the instruction-fetch memory interface. A streaming loader
// fills a word-addressed instruction RAM. The fetch stage then reads it with
// one cycle of latency.
//
// Handshake: the loader may present a word only while ld_ready=1. A word is
// consumed on every clk edge where ld_valid=1 and ld_ready=1 (no back-pressure
// beyond ld_ready). ld_start and ld_done are single-cycle pulses.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   mem_addr      byte fetch address (next PC)
//   mem_out       registered instruction word, one cycle after mem_addr
//   fetch_stall   1 while the memory is not serving reads
//   addr_fault    1 when mem_out is NOP_INSTR due to a bad address
//   ld_start      begin/restart a load at word 0
//   ld_valid      ld_data holds a word
//   ld_data       word to write
//   ld_ready      loader may present words (LOAD state)
//   ld_done       load complete, start execution
//   ld_count      words written in the current load
//   ld_overflow   sticky: a word arrived with the RAM full
//   parity_err    (IMEM_PARITY_EN only) sticky read-parity mismatch
//   dbg_state     current FSM state (0 HALT, 1 LOAD, 2 PRIME, 3 RUN)
//
// Optional feature macro: IMEM_PARITY_EN adds one even-parity bit per RAM
// entry and the parity_err output.
// -----------------------------------------------------------------------------
module imem_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  localparam int         ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  output logic [31:0]       mem_out,
  output logic              fetch_stall,
  output logic              addr_fault,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_overflow,
`ifdef IMEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_LOAD  = 2'd1,
    S_PRIME = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              ld_overflow_q, ld_overflow_d;
  logic [31:0]       mem_out_q;
  logic              addr_fault_q;

  logic [31:0]       ram [DEPTH];

  logic              ld_clear;
  logic              ld_accept;
  logic              wr_en;
  logic              ovf_hit;
  logic              rd_en;
  logic              addr_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HALT;
    else     state_q <= state_d;
  end

  // FSM: next state. ld_start wins over ld_done in LOAD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALT:  if (ld_start) state_d = S_LOAD;
      S_LOAD: begin
        if (ld_start)     state_d = S_LOAD;
        else if (ld_done) state_d = S_PRIME;
      end
      S_PRIME: state_d = S_RUN;
      S_RUN:   if (ld_start) state_d = S_LOAD;
      default: state_d = S_HALT;
    endcase
  end

  // FSM: outputs decoded from the current state
  always_comb begin
    fetch_stall = (state_q != S_RUN);
    ld_ready    = (state_q == S_LOAD);
    dbg_state   = state_q;
  end

  // ---------------------------------------------------------------------------
  // Loader bookkeeping
  // ---------------------------------------------------------------------------
  // PRIME is a fixed one-cycle transit, so ld_start is only honoured elsewhere.
  assign ld_clear  = ld_start && (state_q != S_PRIME);
  // A word arriving together with ld_start is dropped.
  assign ld_accept = (state_q == S_LOAD) && ld_valid && !ld_start;
  assign wr_en     = ld_accept && (ld_count_q != FULL_CNT) && !rst;
  assign ovf_hit   = ld_accept && (ld_count_q == FULL_CNT);
  assign wr_idx    = ld_count_q[ADDR_W-1:0];

  always_comb begin
    ld_count_d    = ld_count_q;
    ld_overflow_d = ld_overflow_q;
    if (ld_clear) begin
      ld_count_d    = '0;
      ld_overflow_d = 1'b0;
    end else begin
      if (wr_en)   ld_count_d    = ld_count_q + 1'b1;
      if (ovf_hit) ld_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count_q    <= '0;
      ld_overflow_q <= 1'b0;
    end else begin
      ld_count_q    <= ld_count_d;
      ld_overflow_q <= ld_overflow_d;
    end
  end

  assign ld_count    = ld_count_q;
  assign ld_overflow = ld_overflow_q;

  // ---------------------------------------------------------------------------
  // RAM write port (loader only)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_idx] <= ld_data;
  end

`ifdef IMEM_PARITY_EN
  logic ram_par [DEPTH];
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (wr_en) ram_par[wr_idx] <= ^ld_data;
  end
`endif

  // ---------------------------------------------------------------------------
  // Read path. Reading whenever the next state is RUN covers the PRIME cycle
  // (so the first RUN cycle sees valid data) and suppresses the read on a RUN
  // cycle that leaves for LOAD, so mem_out is already NOP in the LOAD cycle.
  // ---------------------------------------------------------------------------
  assign rd_en   = (state_d == S_RUN);
  assign addr_ok = (mem_addr[1:0] == 2'b00) && ((mem_addr >> (ADDR_W + 2)) == 32'd0);
  assign rd_idx  = mem_addr[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_out_q    <= NOP_INSTR;
      addr_fault_q <= 1'b0;
    end else if (rd_en && addr_ok) begin
      mem_out_q    <= ram[rd_idx];
      addr_fault_q <= 1'b0;
    end else if (rd_en) begin
      mem_out_q    <= NOP_INSTR;
      addr_fault_q <= 1'b1;
    end else begin
      mem_out_q    <= NOP_INSTR;
      addr_fault_q <= 1'b0;
    end
  end

  assign mem_out    = mem_out_q;
  assign addr_fault = addr_fault_q;

`ifdef IMEM_PARITY_EN
  // Sticky until reset or a new load; the data word itself passes through.
  always_ff @(posedge clk) begin
    if (rst || ld_clear) begin
      parity_err_q <= 1'b0;
    end else if (rd_en && addr_ok && ((^ram[rd_idx]) != ram_par[rd_idx])) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule
